// File: rtl/demux_buffer_pkg.sv
// demux_buffer shared constants: word width, select width, channel count.
// ch_lsb() gives the packed out_data slice offset (ch0 in the top slice).
package demux_buffer_pkg;

    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
    localparam int N_CH  = 1 << SEL_W;
    localparam int OUT_W = N_CH * WIDTH;

    function automatic int ch_lsb(input int ch);
        return (N_CH - 1 - ch) * WIDTH;
    endfunction

endpackage

// File: rtl/demux_buffer_if.sv
// Sample stream in, four channel outputs, round-robin pointer.
// master = producer/consumer side, slave = demux_buffer.
interface demux_buffer_if;
    import demux_buffer_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             rr_mode;
    logic             flush;
    logic [OUT_W-1:0] out_data;
    logic [N_CH-1:0]  out_valid;
    logic [N_CH-1:0]  out_ready;
    logic [SEL_W-1:0] rr_ptr;

    modport master (
        output in_data, in_sel, in_valid, rr_mode, flush, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr
    );

    modport slave (
        input  in_data, in_sel, in_valid, rr_mode, flush, out_ready,
        output in_ready, out_data, out_valid, rr_ptr
    );

endinterface

// File: rtl/demux_buffer_chan_buf.sv
// Single-entry channel buffer: data register plus full bit.
// Ports: i_wr_en load, i_rd_en pop, i_flush clear; o_data, o_full.
module demux_buffer_chan_buf
    import demux_buffer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // A write wins over a pop so a same-cycle refill keeps full set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_wr_en) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_rd_en) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/demux_buffer.sv
// Registered 1:4 demux with per-channel single-entry buffers.
// Ports: clk, rst_n (async low), bus (demux_buffer_if.slave).
module demux_buffer
    import demux_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    demux_buffer_if.slave  bus
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_tgt;
    logic [N_CH-1:0]  w_full;
    logic [N_CH-1:0]  w_wr;
    logic [N_CH-1:0]  w_rd;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_data [N_CH];

    assign w_tgt    = bus.rr_mode ? r_ptr : bus.in_sel;
    // No in_valid term: ready depends only on target state and its pop.
    assign w_ready  = ~bus.flush
                    & (~w_full[w_tgt] | bus.out_ready[w_tgt]);
    assign w_accept = bus.in_valid & w_ready;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign w_wr[g] = w_accept & (w_tgt == SEL_W'(g));
            assign w_rd[g] = w_full[g] & bus.out_ready[g];

            demux_buffer_chan_buf u_buf (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_wr_en (w_wr[g]),
                .i_rd_en (w_rd[g]),
                .i_flush (bus.flush),
                .i_data  (bus.in_data),
                .o_data  (w_data[g]),
                .o_full  (w_full[g])
            );

            assign bus.out_data[ch_lsb(g) +: WIDTH] = w_data[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (bus.flush) begin
            r_ptr <= '0;
        end else if (w_accept & bus.rr_mode) begin
            r_ptr <= r_ptr + SEL_W'(1);
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_full;
    assign bus.rr_ptr    = r_ptr;

endmodule

// File: tb/tb_demux_buffer.sv
// demux_buffer bench: directed cases plus random traffic against
// per-channel expected-word queues and a modulo-4 pointer model.
module tb_demux_buffer;

    logic clk;
    logic rst_n;
    logic mon_en;
    int   n_chk;
    int   n_fail;

    demux_buffer_if bus ();

    demux_buffer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mq [4][$];
    logic [7:0] last_wr [4];
    int         m_ptr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid[%0d]", i),
                    32'(bus.out_valid[i]), 32'(mq[i].size() > 0));
                if (mq[i].size() > 0) begin
                    chk($sformatf("ch%0d_data", i),
                        32'(bus.out_data[(3 - i) * 8 +: 8]),
                        32'(mq[i][0]));
                    if (bus.out_ready[i] && !bus.flush)
                        void'(mq[i].pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d,
                        input logic [1:0] s, input logic rm,
                        input logic fl, input logic [3:0] ordy);
        int  tgt;
        logic exp_rdy;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.rr_mode   = rm;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        #2;
        tgt     = rm ? m_ptr : int'(s);
        exp_rdy = !fl && (mq[tgt].size() == 0);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (fl) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_ptr = 0;
        end else if (v && exp_rdy) begin
            mq[tgt].push_back(d);
            last_wr[tgt] = d;
            if (rm) m_ptr = (m_ptr + 1) % 4;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) last_wr[i] = 8'h00;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.rr_mode   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = '0;
        #13;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_out_data", bus.out_data, 32'd0);
        chk("idle_rr_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;

        step(1, 8'd1, 2'd0, 0, 0, 4'b0000);
        step(1, 8'd11, 2'd1, 0, 0, 4'b0000);
        step(1, 8'd3, 2'd2, 0, 0, 4'b0000);
        step(1, 8'd5, 2'd3, 0, 0, 4'b0000);
        step(1, 8'h2A, 2'd2, 0, 0, 4'b0000);
        chk("explicit_data", bus.out_data, 32'h010B0305);
        chk("explicit_valid", 32'(bus.out_valid), 32'hF);
        step(1, 8'h2A, 2'd2, 0, 0, 4'b0000);
        step(1, 8'h2A, 2'd2, 0, 0, 4'b0100);
        step(0, 8'h00, 2'd0, 0, 0, 4'b1111);
        step(0, 8'h00, 2'd0, 0, 0, 4'b1111);

        for (int k = 0; k < 8; k++)
            step(1, 8'(10 + k), 2'd3, 1, 0, 4'b1111);
        step(0, 8'h00, 2'd0, 1, 0, 4'b1111);
        chk("rr_final_data", bus.out_data, 32'h0E0F1011);

        step(1, 8'd7, 2'd1, 0, 0, 4'b0000);
        step(1, 8'd9, 2'd1, 0, 0, 4'b0010);
        step(0, 8'h00, 2'd0, 0, 0, 4'b0000);
        chk("refill_valid1", 32'(bus.out_valid[1]), 32'd1);
        chk("refill_data1", 32'(bus.out_data[23:16]), 32'd9);

        step(0, 8'h00, 2'd0, 0, 0, 4'b1111);
        step(1, 8'h21, 2'd0, 1, 0, 4'b0000);
        step(1, 8'h24, 2'd3, 0, 0, 4'b0000);
        step(1, 8'h55, 2'd2, 0, 1, 4'b0000);
        step(0, 8'h00, 2'd0, 0, 0, 4'b0000);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("flush_ch2_kept", 32'(bus.out_data[15:8]),
            32'(last_wr[2]));

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(3, 0) != 0, 8'($urandom),
                 2'($urandom), 1'($urandom), $urandom_range(39, 0) == 0,
                 4'($urandom));
        end

        step(0, 8'h00, 2'd0, 1, 1, 4'b0000);
        step(1, 8'h31, 2'd0, 1, 0, 4'b0000);
        step(1, 8'h32, 2'd0, 1, 0, 4'b0000);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        chk("pre_rst_ptr", 32'(bus.rr_ptr), 32'd2);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'b0011);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_data", bus.out_data, 32'd0);
        chk("async_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_ptr = 0;
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 100; k++) begin
            step($urandom_range(1, 0) != 0, 8'($urandom),
                 2'($urandom), 1'($urandom), 1'b0, 4'($urandom));
        end
        step(0, 8'h00, 2'd0, 0, 0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_buffer.md
# demux_buffer

Registered 1-to-4 demultiplexer with per-channel single-entry buffers and valid/ready handshakes. It is the write-side counterpart of the 4:1 `MUX` in the linear-regression datapath. A single 8-bit sample stream is steered into one of four channel registers, either by an explicit select or by an internal round-robin pointer. The block feeds sample/coefficient words (x, y, partial sums) into the four datapath lanes that the `MUX` later reads back.

## Interface
- `WIDTH`, 8, data word width.
- `SEL_W`, 2, select width; channel count is 2**SEL_W = 4 (only 4 is supported).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  sample word.
- `in_sel`  in  SEL_W  destination channel; used only when `rr_mode`=0.
- `in_valid`  in  1  `in_data` and `in_sel` are valid.
- `in_ready`  out  1  block accepts the word this cycle.
- `rr_mode`  in  1  1 = ignore `in_sel` and use the round-robin pointer.
- `flush`  in  1  synchronous clear of all buffers and the pointer.
- `out_data`  out  4*WIDTH  packed channels: ch0 at [4W-1:3W], ch1 at [3W-1:2W], ch2 at [2W-1:W], ch3 at [W-1:0]. This matches the `{in0,in1,in2,in3}` packing of `MUX`.
- `out_valid`  out  4  per-channel buffer full.
- `out_ready`  in  4  per-channel consumer pop.
- `rr_ptr`  out  SEL_W  current round-robin pointer.

## Operation
- Target channel: `tgt = rr_mode ? rr_ptr : in_sel`.
- Each channel holds one entry: a data register plus a `full` bit. `out_valid[i] = full[i]`, and `out_data` slice i is driven directly from data register i.
- `in_ready = ~full[tgt] | out_ready[tgt]`. This is combinational and allows a same-cycle pop-and-refill.
- Accept: `in_valid & in_ready`. On an accept, `data[tgt] <= in_data` and `full[tgt] <= 1`.
- Pop: `out_valid[i] & out_ready[i]`. This clears `full[i]` unless the same channel is being refilled in the same cycle; in that case `full` stays 1 and the data is replaced.
- Pops on channels other than `tgt` are independent and can occur in the same cycle as an accept.
- Round-robin pointer: advances by 1 on every accept while `rr_mode`=1 and wraps 3 -> 0. It holds when `rr_mode`=0 or when there is no accept.
- No word is ever dropped or overwritten while `full`=1 without a pop. If the target buffer is full, the source stalls.
- `flush` clears all `full` bits and sets `rr_ptr` to 0. Data registers are not required to clear. `flush` has priority over an accept and a pop in the same cycle, and `in_ready` is forced to 0 during `flush`.
- Changing `rr_mode` mid-stream is legal. The pointer keeps its value.

## Timing
- Reset values (async, on `rst_n`=0): `full`=0000, `out_valid`=0000, `rr_ptr`=0, data registers = 0, so `out_data`=0. `in_ready` follows its combinational equation, which gives 1 during reset.
- Latency: a word accepted at edge k appears on `out_valid`/`out_data` after edge k, which is 1 cycle.
- Throughput: 1 word/cycle to any single channel, provided its consumer holds `out_ready`=1.
- Combinational paths: `out_ready` -> `in_ready`, `in_sel`/`rr_mode` -> `in_ready`. There is no `in_valid` -> `in_ready` path.
- `rst_n` asserted mid-transfer discards all buffered words immediately.

## Structure
- Shared package/header `demux_pkg`: `WIDTH`, `SEL_W`, `N_CH`=4, and the channel slice-offset macro. The same macro serves `MUX`.
- One natural sub-module is `chan_buf`: a single-entry register that takes `wr_en`, `rd_en` and `flush` and produces `data` and `full`. It is instantiated 4 times by generate.
- The top level holds target selection, `in_ready` generation, and the round-robin counter.

## Test plan
- Reset/idle: hold `rst_n`=0, then release it. Expect `out_valid`=0000, `out_data`=0, `rr_ptr`=0, `in_ready`=1.
- Explicit select: with `rr_mode`=0, send 1, 11, 3, 5 to sel 0, 1, 2, 3 while all `out_ready`=0. Expect `out_data`=32'h010B0305 and `out_valid`=1111. A fifth word to sel 2 then sees `in_ready`=0 and stalls until `out_ready[2]`=1.
- Round-robin: with `rr_mode`=1 and all `out_ready`=1, stream 8 words (10 through 17). Each channel updates in order 0,1,2,3,0,…, `rr_ptr` reads 0,1,2,3,0,1,2,3,0, and the final `out_data`=32'h0E0F1011.
- Same-cycle pop and refill: ch1 is full with 7. Drive `in_sel`=1, `in_data`=9 and `out_ready[1]`=1 together. Expect `in_ready`=1, `out_valid[1]` stays 1, and ch1 reads 9 on the next cycle.
- Flush priority: with ch0 and ch3 full, assert `flush` together with `in_valid` to ch2. Expect `in_ready`=0, `out_valid`=0000 and `rr_ptr`=0 the next cycle, and ch2 is not written.
- Async reset mid-stream: with `rr_mode`=1 and `rr_ptr`=2 and two channels full, pulse `rst_n` low between clock edges. Outputs clear before the next edge.
